sub_stage_control: RTL and testbench
====================================

SUB_STAGE_CONTROL -- requirements
Module: sub_stage_control

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset in 1, asynchronous active-high reset.
REQ-002 SHALL have inputs: op 7 (IR[6:0]); funct3 3 (IR[14:12]); funct7 7 (IR[31:25]); cmpTrue 1 (ALU aluResult[0]); memReady 1 (memory access complete this cycle).
REQ-003 SHALL have outputs: pcWrite 1; adrSrc 1 (0=PC, 1=result bus); memWrite 1; irWrite 1; regWrite 1; resultSrc 2 (00=ALUOut, 01=data reg, 10=aluResult); aluSrcA 2 (00=PC, 01=oldPC, 10=rs1 reg, 11=zero); aluSrcB 2 (00=rs2 reg, 01=immExt, 10=const 4); aluControl 4; halted 1.
REQ-004 SHALL drive aluControl codes: ADD 0000, SUB 0001, AND 0010, SRA 0011, OR 0100, XOR 0110, SLL 0111, SRL 1000, EQ 1001, LT (signed) 1011, LTU 1100, MUL 1110, DIVU 1111.

Function
REQ-005 SHALL be a Moore FSM on clk; outputs decode from registered state, except pcWrite/irWrite, which also gate on memReady or cmpTrue.
REQ-006 SHALL, in every state, default the write enables (pcWrite, memWrite, irWrite, regWrite) to 0 and halted to 0.
REQ-007 FETCH: adrSrc=0, aluSrcA=00, aluSrcB=10, ADD, resultSrc=10; irWrite=pcWrite=memReady; stay until memReady=1, then DECODE.
REQ-008 DECODE: aluSrcA=01, aluSrcB=01, ADD (branch/JAL/AUIPC target into ALUOut).
REQ-009 DECODE next state: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JMP, 1100111->JALR, 0110111->LUI, 0010111->ALUWB, any other op (including 1110011)->HALT.
REQ-010 MEMADR: aluSrcA=10, aluSrcB=01, ADD; next MEMREAD if op=0000011, else MEMWRITE.
REQ-011 MEMREAD: adrSrc=1, resultSrc=00; hold until memReady, then MEMWB.
REQ-012 MEMWB: resultSrc=01, regWrite=1; next FETCH.
REQ-013 MEMWRITE: adrSrc=1, resultSrc=00, memWrite=1, held until memReady; then FETCH.
REQ-014 EXECR: aluSrcA=10, aluSrcB=00. EXECI: aluSrcA=10, aluSrcB=01. Both go to ALUWB.
REQ-015 EXECR/EXECI op by funct3: 000 ADD (SUB if EXECR and funct7=0100000), 001 SLL, 010 LT, 011 LTU, 100 XOR, 101 SRL (SRA if funct7=0100000), 110 OR, 111 AND.
REQ-016 ALUWB: resultSrc=00, regWrite=1; next FETCH.
REQ-017 BRANCH: aluSrcA=10, aluSrcB=00, resultSrc=00; op EQ for funct3 00x, LT for 10x, LTU for 11x; pcWrite=cmpTrue XOR funct3[0]; next FETCH.
REQ-018 JALR: aluSrcA=10, aluSrcB=01, ADD; next JMP.
REQ-019 JMP: aluSrcA=01, aluSrcB=10, ADD, resultSrc=00, pcWrite=1; next ALUWB (rd = oldPC+4).
REQ-020 LUI: aluSrcA=11, aluSrcB=01, ADD; next ALUWB.
REQ-021 HALT: halted=1, all enables 0; remain until reset.
REQ-022 SHALL route to HALT from DECODE on: BRANCH funct3 010/011; EXECR funct7 not in {0000000, 0100000}; 0100000 with funct3 not in {000, 101}; EXECI funct3=101 with funct7 not in {0000000, 0100000}; EXECI funct3=001 with funct7!=0000000.
REQ-023 SHALL hold FETCH/MEMREAD/MEMWRITE indefinitely while memReady=0, with outputs stable.

Reset
REQ-024 SHALL, on reset=1, immediately enter FETCH asynchronously; all write enables 0, halted 0, aluControl ADD.
REQ-025 SHALL, on reset asserted mid-MEMWRITE, drop memWrite in the same cycle, without waiting for clk.

Configuration
REQ-026 SHALL, with MULDIV_EN defined, decode EXECR funct7=0000001: funct3 000 -> MUL, 101 -> DIVU, other -> HALT.
REQ-027 SHALL, without MULDIV_EN, route funct7=0000001 to HALT; codes 1110/1111 are never driven.

Verification
REQ-028 add x3,x1,x2 (op 0110011, funct3 000, funct7 0), memReady=1 -> FETCH, DECODE, EXECR (ADD), ALUWB; regWrite=1 once; 4 cycles.
REQ-029 lw with memReady low 3 cycles in MEMREAD -> state held 3 cycles, then MEMWB regWrite=1 with resultSrc=01.
REQ-030 bne (funct3 001), cmpTrue=0 -> pcWrite=1 in BRANCH with aluControl=1001; cmpTrue=1 -> pcWrite=0.
REQ-031 jalr -> JALR (A+imm), JMP pcWrite=1 resultSrc=00, ALUWB regWrite=1.
REQ-032 op 1110011 -> HALT, halted=1 for 10+ cycles; reset -> FETCH, halted=0.
REQ-033 mul (funct7 0000001, funct3 000) -> aluControl 1110 with MULDIV_EN; HALT without it.

Source files
------------

// File: rtl/sub_stage_control.sv
// Multicycle RV32 control FSM: sequences fetch, decode, execute, memory and writeback steps.
// Define MULDIV_EN to decode the R-type MUL/DIVU extension (funct7 0000001).
module sub_stage_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       cmpTrue,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [3:0] aluControl,
    output logic       halted
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_SRA  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_EQ   = 4'b1001;
    localparam logic [3:0] ALU_LT   = 4'b1011;
    localparam logic [3:0] ALU_LTU  = 4'b1100;
`ifdef MULDIV_EN
    localparam logic [3:0] ALU_MUL  = 4'b1110;
    localparam logic [3:0] ALU_DIVU = 4'b1111;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
`endif

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] A_PC    = 2'b00;
    localparam logic [1:0] A_OLDPC = 2'b01;
    localparam logic [1:0] A_RS1   = 2'b10;
    localparam logic [1:0] A_ZERO  = 2'b11;
    localparam logic [1:0] B_RS2   = 2'b00;
    localparam logic [1:0] B_IMM   = 2'b01;
    localparam logic [1:0] B_FOUR  = 2'b10;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JALR, JMP, LUI, HALT
    } state_t;

    state_t state, nextState;

    function automatic logic rLegal(input logic [2:0] f3, input logic [6:0] f7);
        logic ok;
        case (f7)
            F7_BASE:   ok = 1'b1;
            F7_ALT:    ok = (f3 == 3'b000) || (f3 == 3'b101);
`ifdef MULDIV_EN
            F7_MULDIV: ok = (f3 == 3'b000) || (f3 == 3'b101);
`endif
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Shift-immediates carry funct7 in the immediate field, so only they are constrained.
    function automatic logic iLegal(input logic [2:0] f3, input logic [6:0] f7);
        logic ok;
        ok = 1'b1;
        if (f3 == 3'b001)
            ok = (f7 == F7_BASE);
        else if (f3 == 3'b101)
            ok = (f7 == F7_BASE) || (f7 == F7_ALT);
        return ok;
    endfunction

    function automatic logic [3:0] aluOp(input logic [2:0] f3, input logic [6:0] f7,
                                         input logic isR);
        logic [3:0] code;
        logic alt;
        alt = (f7 == F7_ALT);
        case (f3)
            3'b000:  code = (isR && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_LT;
            3'b011:  code = ALU_LTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
`ifdef MULDIV_EN
        if (isR && (f7 == F7_MULDIV))
            code = (f3 == 3'b101) ? ALU_DIVU : ALU_MUL;
`endif
        return code;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= FETCH;
        else
            state <= nextState;
    end

    always_comb begin
        nextState  = state;
        pcWrite    = 1'b0;
        adrSrc     = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        regWrite   = 1'b0;
        resultSrc  = RES_ALUOUT;
        aluSrcA    = A_PC;
        aluSrcB    = B_RS2;
        aluControl = ALU_ADD;
        halted     = 1'b0;
        case (state)
            FETCH: begin
                aluSrcB   = B_FOUR;
                resultSrc = RES_ALURESULT;
                irWrite   = memReady;
                pcWrite   = memReady;
                if (memReady)
                    nextState = DECODE;
            end
            DECODE: begin
                aluSrcA = A_OLDPC;
                aluSrcB = B_IMM;
                case (op)
                    OP_LOAD, OP_STORE: nextState = MEMADR;
                    OP_RTYPE:  nextState = rLegal(funct3, funct7) ? EXECR : HALT;
                    OP_ITYPE:  nextState = iLegal(funct3, funct7) ? EXECI : HALT;
                    OP_BRANCH: nextState = (funct3[2:1] == 2'b01) ? HALT : BRANCH;
                    OP_JAL:    nextState = JMP;
                    OP_JALR:   nextState = JALR;
                    OP_LUI:    nextState = LUI;
                    OP_AUIPC:  nextState = ALUWB;
                    default:   nextState = HALT;
                endcase
            end
            MEMADR: begin
                aluSrcA   = A_RS1;
                aluSrcB   = B_IMM;
                nextState = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adrSrc = 1'b1;
                if (memReady)
                    nextState = MEMWB;
            end
            MEMWB: begin
                resultSrc = RES_DATA;
                regWrite  = 1'b1;
                nextState = FETCH;
            end
            MEMWRITE: begin
                adrSrc   = 1'b1;
                memWrite = 1'b1;
                if (memReady)
                    nextState = FETCH;
            end
            EXECR, EXECI: begin
                aluSrcA    = A_RS1;
                aluSrcB    = (state == EXECI) ? B_IMM : B_RS2;
                aluControl = aluOp(funct3, funct7, state == EXECR);
                nextState  = ALUWB;
            end
            ALUWB: begin
                regWrite  = 1'b1;
                nextState = FETCH;
            end
            BRANCH: begin
                aluSrcA = A_RS1;
                case (funct3[2:1])
                    2'b00:   aluControl = ALU_EQ;
                    2'b10:   aluControl = ALU_LT;
                    default: aluControl = ALU_LTU;
                endcase
                // funct3[0] selects the negated sense (bne/bge/bgeu).
                pcWrite   = cmpTrue ^ funct3[0];
                nextState = FETCH;
            end
            JALR: begin
                aluSrcA   = A_RS1;
                aluSrcB   = B_IMM;
                nextState = JMP;
            end
            JMP: begin
                aluSrcA   = A_OLDPC;
                aluSrcB   = B_FOUR;
                pcWrite   = 1'b1;
                nextState = ALUWB;
            end
            LUI: begin
                aluSrcA   = A_ZERO;
                aluSrcB   = B_IMM;
                nextState = ALUWB;
            end
            HALT: halted = 1'b1;
            default: nextState = HALT;
        endcase
        // FETCH passes memReady straight through, so enables are forced off while reset is held.
        if (reset) begin
            pcWrite  = 1'b0;
            memWrite = 1'b0;
            irWrite  = 1'b0;
            regWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_sub_stage_control.sv
// Directed bench for sub_stage_control: an instruction-level model expands each instruction
// into its expected per-cycle outputs, and a negedge compare process checks them.
module tb_sub_stage_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       cmpTrue = 1'b0;
    logic       memReady = 1'b0;
    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, halted;
    logic [1:0] resultSrc, aluSrcA, aluSrcB;
    logic [3:0] aluControl;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int pcW, adr, memW, irW, regW, res, srcA, srcB, alu, halt;
    } rec_t;

    rec_t expQ[$];

    sub_stage_control dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
        .cmpTrue(cmpTrue), .memReady(memReady), .pcWrite(pcWrite), .adrSrc(adrSrc),
        .memWrite(memWrite), .irWrite(irWrite), .regWrite(regWrite), .resultSrc(resultSrc),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluControl(aluControl), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chkField(input string name, input int act, input int req);
        if (req >= 0) chk(name, act, req);
    endtask

    always @(negedge clk) begin
        rec_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            chkField("pcWrite", pcWrite, e.pcW);
            chkField("adrSrc", adrSrc, e.adr);
            chkField("memWrite", memWrite, e.memW);
            chkField("irWrite", irWrite, e.irW);
            chkField("regWrite", regWrite, e.regW);
            chkField("resultSrc", resultSrc, e.res);
            chkField("aluSrcA", aluSrcA, e.srcA);
            chkField("aluSrcB", aluSrcB, e.srcB);
            chkField("aluControl", aluControl, e.alu);
            chkField("halted", halted, e.halt);
        end
    end

    // ALU code an R/I-type instruction must use, or -1 when it must halt.
    function automatic int execCode(input bit isR, input int f3, input int f7);
        if (isR) begin
            if (f7 == 1) begin
`ifdef MULDIV_EN
                return (f3 == 0) ? 14 : (f3 == 5) ? 15 : -1;
`else
                return -1;
`endif
            end
            if (f7 != 0 && f7 != 32) return -1;
            if (f7 == 32 && f3 != 0 && f3 != 5) return -1;
        end else begin
            if (f3 == 1 && f7 != 0) return -1;
            if (f3 == 5 && f7 != 0 && f7 != 32) return -1;
        end
        case (f3)
            0: return (isR && f7 == 32) ? 1 : 0;
            1: return 7;
            2: return 11;
            3: return 12;
            4: return 6;
            5: return (f7 == 32) ? 3 : 8;
            6: return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int branchCode(input int f3);
        case (f3 / 2)
            0: return 9;
            2: return 11;
            3: return 12;
            default: return -1;
        endcase
    endfunction

    function automatic rec_t base();
        rec_t r;
        r.pcW = 0; r.memW = 0; r.irW = 0; r.regW = 0; r.halt = 0;
        r.adr = -1; r.res = -1; r.srcA = -1; r.srcB = -1; r.alu = -1;
        return r;
    endfunction

    function automatic rec_t aluRec(input int a, input int b, input int alu);
        rec_t r;
        r = base(); r.srcA = a; r.srcB = b; r.alu = alu;
        return r;
    endfunction

    function automatic rec_t fetchR(input bit mr);
        rec_t r;
        r = aluRec(0, 2, 0); r.adr = 0; r.res = 2; r.irW = mr; r.pcW = mr;
        return r;
    endfunction

    function automatic rec_t memAccessR(input bit isWrite);
        rec_t r;
        r = base(); r.adr = 1; r.res = 0; r.memW = isWrite;
        return r;
    endfunction

    function automatic rec_t wbR(input int res);
        rec_t r;
        r = base(); r.res = res; r.regW = 1;
        return r;
    endfunction

    function automatic rec_t haltR();
        rec_t r;
        r = base(); r.halt = 1;
        return r;
    endfunction

    task automatic cyc(input bit mr, input bit cmp, input rec_t r);
        memReady = mr;
        cmpTrue  = cmp;
        expQ.push_back(r);
        @(posedge clk); #1;
    endtask

    // Entered and left at posedge+1; the DUT sits in FETCH on return.
    task automatic doReset();
        memReady = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_pcWrite", pcWrite, 0);
        chk("rst_irWrite", irWrite, 0);
        chk("rst_memWrite", memWrite, 0);
        chk("rst_regWrite", regWrite, 0);
        chk("rst_halted", halted, 0);
        chk("rst_aluControl", aluControl, 0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic runInstr(input int opc, input int f3, input int f7, input int fWait,
                            input int mWait, input bit cmp, input int haltCycles);
        int code;
        bit doHalt;
        rec_t r;
        op = 7'(opc); funct3 = 3'(f3); funct7 = 7'(f7);
        doHalt = 1'b0;
        for (int i = 0; i < fWait; i++) cyc(1'b0, cmp, fetchR(1'b0));
        cyc(1'b1, cmp, fetchR(1'b1));
        cyc(1'b1, cmp, aluRec(1, 1, 0));
        case (opc)
            7'b0000011, 7'b0100011: begin
                cyc(1'b1, cmp, aluRec(2, 1, 0));
                for (int i = 0; i < mWait; i++) cyc(1'b0, cmp, memAccessR(opc == 7'b0100011));
                cyc(1'b1, cmp, memAccessR(opc == 7'b0100011));
                if (opc == 7'b0000011) cyc(1'b1, cmp, wbR(1));
            end
            7'b0110011, 7'b0010011: begin
                code = execCode(opc == 7'b0110011, f3, f7);
                if (code < 0) doHalt = 1'b1;
                else begin
                    cyc(1'b1, cmp, aluRec(2, (opc == 7'b0110011) ? 0 : 1, code));
                    cyc(1'b1, cmp, wbR(0));
                end
            end
            7'b1100011: begin
                code = branchCode(f3);
                if (code < 0) doHalt = 1'b1;
                else begin
                    r = aluRec(2, 0, code); r.res = 0; r.pcW = cmp ^ f3[0];
                    cyc(1'b1, cmp, r);
                end
            end
            7'b1101111, 7'b1100111: begin
                if (opc == 7'b1100111) cyc(1'b1, cmp, aluRec(2, 1, 0));
                r = aluRec(1, 2, 0); r.res = 0; r.pcW = 1;
                cyc(1'b1, cmp, r);
                cyc(1'b1, cmp, wbR(0));
            end
            7'b0110111: begin
                cyc(1'b1, cmp, aluRec(3, 1, 0));
                cyc(1'b1, cmp, wbR(0));
            end
            7'b0010111: cyc(1'b1, cmp, wbR(0));
            default: doHalt = 1'b1;
        endcase
        if (doHalt) begin
            for (int i = 0; i < haltCycles; i++) cyc(1'b1, cmp, haltR());
            doReset();
        end
    endtask

    initial begin
        // Hand-computed pins on the model's code tables.
        chk("model_add", execCode(1'b1, 0, 0), 0);
        chk("model_sub", execCode(1'b1, 0, 32), 1);
        chk("model_srai", execCode(1'b0, 5, 32), 3);
        chk("model_bne", branchCode(1), 9);
        chk("model_bgeu", branchCode(7), 12);
        chk("model_badBranch", branchCode(2), -1);

        repeat (2) @(posedge clk);
        #1;
        doReset();

        runInstr(7'b0110011, 0, 0, 0, 0, 1'b0, 0);            // add x3,x1,x2
        for (int f = 0; f < 8; f++) runInstr(7'b0110011, f, 0, 0, 0, 1'b0, 0);
        runInstr(7'b0110011, 0, 32, 0, 0, 1'b0, 0);           // sub
        runInstr(7'b0110011, 5, 32, 0, 0, 1'b0, 0);           // sra
        runInstr(7'b0010011, 0, 32, 0, 0, 1'b0, 0);           // addi with imm bits set
        runInstr(7'b0010011, 5, 32, 0, 0, 1'b0, 0);           // srai
        runInstr(7'b0010011, 1, 0, 0, 0, 1'b0, 0);            // slli
        runInstr(7'b0010011, 4, 85, 0, 0, 1'b0, 0);           // xori
        runInstr(7'b0000011, 2, 0, 2, 3, 1'b0, 0);            // lw, fetch and read stalls
        runInstr(7'b0100011, 2, 0, 0, 2, 1'b0, 0);            // sw with write stall
        runInstr(7'b1100011, 1, 0, 0, 0, 1'b0, 0);            // bne, not equal -> taken
        runInstr(7'b1100011, 1, 0, 0, 0, 1'b1, 0);            // bne, equal -> not taken
        runInstr(7'b1100011, 0, 0, 0, 0, 1'b1, 0);            // beq taken
        runInstr(7'b1100011, 4, 0, 0, 0, 1'b0, 0);            // blt not taken
        runInstr(7'b1100011, 7, 0, 0, 0, 1'b1, 0);            // bgeu not taken
        runInstr(7'b1101111, 0, 0, 0, 0, 1'b0, 0);            // jal
        runInstr(7'b1100111, 0, 0, 0, 0, 1'b0, 0);            // jalr
        runInstr(7'b0110111, 0, 0, 0, 0, 1'b0, 0);            // lui
        runInstr(7'b0010111, 0, 0, 0, 0, 1'b0, 0);            // auipc
        runInstr(7'b1110011, 0, 0, 0, 0, 1'b0, 12);           // ecall -> halt
        runInstr(7'b0110011, 0, 1, 0, 0, 1'b0, 3);            // mul
        runInstr(7'b0110011, 5, 1, 0, 0, 1'b0, 3);            // divu
        runInstr(7'b0110011, 1, 1, 0, 0, 1'b0, 3);            // muldiv funct3 001 -> halt
        runInstr(7'b1100011, 2, 0, 0, 0, 1'b0, 3);            // illegal branch
        runInstr(7'b0110011, 0, 16, 0, 0, 1'b0, 3);           // bad funct7
        runInstr(7'b0110011, 1, 32, 0, 0, 1'b0, 3);           // alt funct7 on sll
        runInstr(7'b0010011, 5, 16, 0, 0, 1'b0, 3);           // bad shift-immediate
        runInstr(7'b0010011, 1, 32, 0, 0, 1'b0, 3);           // slli with funct7 set
        runInstr(7'b0000000, 0, 0, 0, 0, 1'b0, 3);            // unknown opcode
        runInstr(7'b0110011, 4, 0, 0, 0, 1'b0, 0);            // xor after recovery

        // Reset while a store is stalled must drop memWrite without a clock edge.
        op = 7'b0100011; funct3 = 3'd2; funct7 = 7'd0;
        cyc(1'b1, 1'b0, fetchR(1'b1));
        cyc(1'b1, 1'b0, aluRec(1, 1, 0));
        cyc(1'b1, 1'b0, aluRec(2, 1, 0));
        cyc(1'b0, 1'b0, memAccessR(1'b1));
        cyc(1'b0, 1'b0, memAccessR(1'b1));
        #1;
        chk("memWrite_beforeReset", memWrite, 1);
        reset = 1'b1;
        #1;
        chk("memWrite_asyncReset", memWrite, 0);
        chk("adrSrc_asyncReset", adrSrc, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        runInstr(7'b0110011, 0, 0, 0, 0, 1'b0, 0);

        @(posedge clk); #1;
        chk("queue_drained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
